// File: rtl/router_fsm.sv
// ----------------------------------------------------------------------------
// router_fsm -- write-side control FSM of a 3-port packet router.
//
// Purpose
//   Decodes the header address of an incoming packet and sequences the writes
//   into the addressed FIFO. It waits for that FIFO to drain if it is not
//   empty, stalls while it is full, and steps through the parity byte and the
//   parity check. Address 3 is not a valid destination, so such packets are
//   dropped in DECODE_ADDRESS. A read-timeout soft reset of the addressed FIFO
//   aborts the packet.
//
//   Moore machine. The next state is computed combinationally, and every
//   output is registered from the next-state decode. Each output therefore
//   reflects the current state, and no input reaches an output without
//   passing through a flop.
//
// Configuration
//   ROUTER_FSM_WDOG_EN : when defined, a 5-bit watchdog limits how long the
//                        FSM may sit in FIFO_FULL_STATE or WAIT_TILL_EMPTY.
//                        On expiry the FSM returns to DECODE_ADDRESS and
//                        wdog_timeout pulses for one cycle. When undefined,
//                        there is no counter and wdog_timeout is tied to 0.
//                        The port list is the same in both builds.
//
// Ports
//   clock              in   rising-edge clock
//   resetn             in   synchronous active-low reset
//   pkt_valid          in   source packet-valid strobe
//   data_in[1:0]       in   header address bits
//   fifo_full          in   full flag of the addressed FIFO
//   fifo_empty_0/1/2   in   per-FIFO empty flags
//   soft_reset_0/1/2   in   per-FIFO read-timeout resets
//   parity_done        in   parity byte captured by the register block
//   low_packet_valid   in   pkt_valid fell while loading
//   detect_add         out  state == DECODE_ADDRESS
//   lfd_state          out  state == LOAD_FIRST_DATA
//   ld_state           out  state == LOAD_DATA
//   laf_state          out  state == LOAD_AFTER_FULL
//   full_state         out  state == FIFO_FULL_STATE
//   rst_int_reg        out  state == CHECK_PARITY_ERROR
//   write_enb_reg      out  LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
//   busy               out  all states except DECODE_ADDRESS and LOAD_DATA
//   wdog_timeout       out  one-cycle watchdog expiry pulse
// ----------------------------------------------------------------------------
module router_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy,
    output logic       wdog_timeout
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    state_e     state_q;
    state_e     state_nxt;   // transition before the watchdog override
    state_e     state_d;
    logic [1:0] target_q;
    logic [1:0] target_d;

    // Flags are packed into 4-bit vectors with bit 3 tied low. An address-3
    // lookup therefore reads 0 instead of indexing out of range.
    logic [3:0] empty_v;
    logic [3:0] srst_v;
    logic       hdr_ok;

    assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign srst_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign hdr_ok  = pkt_valid && (data_in != 2'd3);

    // ------------------------------------------------------------------
    // Base next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_ok)
                    state_nxt = empty_v[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA:    state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_nxt = FIFO_FULL_STATE;
                else if (!pkt_valid) state_nxt = LOAD_PARITY;
                else                 state_nxt = LOAD_DATA;
            end
            LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
            FIFO_FULL_STATE:    state_nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)           state_nxt = DECODE_ADDRESS;
                else if (low_packet_valid) state_nxt = LOAD_PARITY;
                else                       state_nxt = LOAD_DATA;
            end
            CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:    state_nxt = empty_v[target_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            default:            state_nxt = DECODE_ADDRESS;
        endcase
        // A read timeout on the FIFO being written abandons the packet.
        // Timeouts on the other FIFOs belong to other readers and are ignored.
        if ((state_q != DECODE_ADDRESS) && srst_v[target_q])
            state_nxt = DECODE_ADDRESS;
    end

    // The destination is captured only when a valid header is accepted.
    // It is held through the packet, so the flag lookups keep using it.
    assign target_d = ((state_q == DECODE_ADDRESS) && hdr_ok) ? data_in : target_q;

`ifdef ROUTER_FSM_WDOG_EN
    // ------------------------------------------------------------------
    // Watchdog on the two waiting states
    // ------------------------------------------------------------------
    logic [4:0] wdog_q;
    logic [4:0] wdog_d;
    logic       wdog_stay;
    logic       wdog_fire;

    // The count runs only while the FSM stays in a waiting state; any state
    // change restarts it. The watchdog fires on the cycle whose increment
    // would take the count to 31. The FSM therefore leaves after exactly
    // 31 cycles in the waiting state.
    always_comb begin
        wdog_stay = ((state_q == FIFO_FULL_STATE) || (state_q == WAIT_TILL_EMPTY)) &&
                    (state_nxt == state_q);
        wdog_fire = wdog_stay && (wdog_q == 5'd30);
        wdog_d    = (wdog_stay && !wdog_fire) ? (wdog_q + 5'd1) : 5'd0;
        state_d   = wdog_fire ? DECODE_ADDRESS : state_nxt;
    end
`else
    always_comb begin
        state_d = state_nxt;
    end

    assign wdog_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State, target and registered Moore outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= DECODE_ADDRESS;
            target_q      <= 2'd0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            busy          <= 1'b0;
`ifdef ROUTER_FSM_WDOG_EN
            wdog_q        <= 5'd0;
            wdog_timeout  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            // Outputs are decoded from the next state. The registered value
            // then matches the state the FSM is in during the following cycle.
            detect_add    <= (state_d == DECODE_ADDRESS);
            lfd_state     <= (state_d == LOAD_FIRST_DATA);
            ld_state      <= (state_d == LOAD_DATA);
            laf_state     <= (state_d == LOAD_AFTER_FULL);
            full_state    <= (state_d == FIFO_FULL_STATE);
            rst_int_reg   <= (state_d == CHECK_PARITY_ERROR);
            write_enb_reg <= (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                             (state_d == LOAD_AFTER_FULL);
            busy          <= (state_d != DECODE_ADDRESS) && (state_d != LOAD_DATA);
`ifdef ROUTER_FSM_WDOG_EN
            wdog_q        <= wdog_d;
            // The pulse coincides with the first DECODE_ADDRESS cycle after
            // the expiry.
            wdog_timeout  <= wdog_fire;
`endif
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// ----------------------------------------------------------------------------
// tb_router_fsm -- self-checking bench for router_fsm.
// Each step pushes the expected output vector for the coming edge into a
// scoreboard queue. It then clocks the DUT and records the observed vector.
// Each scenario task drains both queues and compares them.
// Output vector order:
//   {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, wdog_timeout}
// ----------------------------------------------------------------------------
module tb_router_fsm;

    localparam int DA  = 0;
    localparam int LFD = 1;
    localparam int LD  = 2;
    localparam int LP  = 3;
    localparam int FFS = 4;
    localparam int LAF = 5;
    localparam int WTE = 6;
    localparam int CPE = 7;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy, wdog_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];

    router_fsm dut (
        .clock            (clock),
        .resetn           (resetn),
        .pkt_valid        (pkt_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .fifo_empty_0     (fifo_empty_0),
        .fifo_empty_1     (fifo_empty_1),
        .fifo_empty_2     (fifo_empty_2),
        .soft_reset_0     (soft_reset_0),
        .soft_reset_1     (soft_reset_1),
        .soft_reset_2     (soft_reset_2),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .laf_state        (laf_state),
        .full_state       (full_state),
        .rst_int_reg      (rst_int_reg),
        .write_enb_reg    (write_enb_reg),
        .busy             (busy),
        .wdog_timeout     (wdog_timeout)
    );

    always #5 clock = ~clock;

    // Expected output vector for a given state, using the state-to-output table.
    function automatic logic [8:0] ov(input int st, input logic wd);
        logic [8:0] v;
        v    = '0;
        v[8] = (st == DA);
        v[7] = (st == LFD);
        v[6] = (st == LD);
        v[5] = (st == LAF);
        v[4] = (st == FFS);
        v[3] = (st == CPE);
        v[2] = (st == LD) || (st == LP) || (st == LAF);
        v[1] = !((st == DA) || (st == LD));
        v[0] = wd;
        return v;
    endfunction

    task automatic step(input int st, input logic wd = 1'b0);
        exp_q.push_back(ov(st, wd));
        @(posedge clock);
        #1;
        obs_q.push_back({detect_add, lfd_state, ld_state, laf_state, full_state,
                         rst_int_reg, write_enb_reg, busy, wdog_timeout});
    endtask

    task automatic idle();
        resetn = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_packet_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] e, o;
        int i;
        idle();
        resetn = 1'b0; pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
        step(DA);
        step(DA);
        resetn = 1'b1; pkt_valid = 1'b0;
        step(DA);
        n_checks++;
        if (dut.target_q !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_target: got %0d expected 0", dut.target_q);
        end
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: got %b expected %b", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_load();
        logic [8:0] e, o;
        int i;
        idle();
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
        step(LFD);
        data_in = 2'd3; fifo_empty_1 = 1'b0;   // payload bits must be ignored
        step(LD);
        step(LD);
        pkt_valid = 1'b0;
        step(LP);
        step(CPE);
        step(DA);
        n_checks++;
        if (dut.target_q !== 2'd1) begin
            n_fail++;
            $display("FAIL load_target: got %0d expected 1", dut.target_q);
        end
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL load step %0d: got %b expected %b", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_fifo_full();
        logic [8:0] e, o;
        int i;
        idle();
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
        step(LFD);
        fifo_empty_0 = 1'b0;
        step(LD);
        fifo_full = 1'b1;
        step(FFS); step(FFS); step(FFS);
        fifo_full = 1'b0;
        step(LAF);
        step(LD);                               // LAF, no parity, no low pv
        step(LD);
        pkt_valid = 1'b0; fifo_full = 1'b1;    // full wins over pkt_valid drop
        step(FFS);
        fifo_full = 1'b0;
        step(LAF);
        low_packet_valid = 1'b1;
        step(LP);
        low_packet_valid = 1'b0; fifo_full = 1'b1;
        step(CPE);
        step(FFS);                              // CPE with full -> FFS
        fifo_full = 1'b0;
        step(LAF);
        parity_done = 1'b1;
        step(DA);
        parity_done = 1'b0;
        step(DA);
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL fifo_full step %0d: got %b expected %b", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_wait_soft_reset();
        logic [8:0] e, o;
        int i;
        idle();
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        step(WTE);
        pkt_valid = 1'b0; soft_reset_0 = 1'b1;
        step(WTE);
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
        step(WTE);
        soft_reset_1 = 1'b0; soft_reset_2 = 1'b1;
        step(DA);
        step(DA);                               // soft reset ignored in DA
        soft_reset_2 = 1'b0;
        pkt_valid = 1'b1; data_in = 2'd2;
        step(WTE);
        pkt_valid = 1'b0; data_in = 2'd0; fifo_empty_0 = 1'b1;  // wrong FIFO
        step(WTE);
        fifo_empty_2 = 1'b1;
        step(LFD);
        soft_reset_2 = 1'b1;                    // overrides LFD -> LD
        step(DA);
        soft_reset_2 = 1'b0;
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wait_soft step %0d: got %b expected %b", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_addr3();
        logic [8:0] e, o;
        int i;
        idle();
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        pkt_valid = 1'b1; data_in = 2'd3;
        step(DA);
        step(DA);
        n_checks++;
        if (dut.target_q !== 2'd2) begin
            n_fail++;
            $display("FAIL addr3_target: got %0d expected 2", dut.target_q);
        end
        pkt_valid = 1'b0; data_in = 2'd1;
        step(DA);
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL addr3 step %0d: got %b expected %b", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_wdog();
        logic [8:0] e, o;
        int i;
        idle();
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
        step(LFD);
        step(LD);
        fifo_full = 1'b1;
`ifdef ROUTER_FSM_WDOG_EN
        repeat (31) step(FFS);
        step(DA, 1'b1);
        fifo_full = 1'b0; pkt_valid = 1'b0;
        step(DA, 1'b0);
`else
        repeat (40) step(FFS);
        fifo_full = 1'b0;
        step(LAF);
        parity_done = 1'b1;
        step(DA);
        parity_done = 1'b0; pkt_valid = 1'b0;
`endif
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wdog step %0d: got %b expected %b", i, o, e);
            end
            i++;
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [8:0] e, o;
        int i;
        idle();
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b1;
        step(LFD);
        step(LD);
        resetn = 1'b0;
        step(DA);
        n_checks++;
        if (dut.target_q !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_target: got %0d expected 0", dut.target_q);
        end
        resetn = 1'b1; pkt_valid = 1'b0;
        step(DA);
        i = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %b expected %b", i, o, e);
            end
            i++;
        end
    endtask

    initial begin
        idle();
        #2;
        test_reset();
        test_load();
        test_fifo_full();
        test_wait_soft_reset();
        test_addr3();
        test_wdog();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 The block SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-002 The block SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-003 The block SHALL have port pkt_valid, input, 1, source packet-valid strobe.
REQ-004 The block SHALL have port data_in, input, 2, address bits [1:0] of the header byte.
REQ-005 The block SHALL have port fifo_full, input, 1, full flag of the currently addressed FIFO.
REQ-006 The block SHALL have ports fifo_empty_0/1/2, input, 1 each, per-FIFO empty flags.
REQ-007 The block SHALL have ports soft_reset_0/1/2, input, 1 each, per-FIFO read-timeout resets.
REQ-008 The block SHALL have port parity_done, input, 1, parity byte captured by the register block.
REQ-009 The block SHALL have port low_packet_valid, input, 1, pkt_valid fell while loading.
REQ-010 The block SHALL have outputs detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg and busy, 1 bit each.
REQ-011 The block SHALL have output wdog_timeout, 1, one-cycle watchdog pulse.

Function
REQ-012 The FSM SHALL implement eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY and CHECK_PARITY_ERROR.
REQ-013 The FSM SHALL be a Moore machine: all outputs decode from the current state only, with zero combinational input-to-output paths.
REQ-014 The FSM SHALL drive the outputs as follows: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR; write_enb_reg=LOAD_DATA|LOAD_PARITY|LOAD_AFTER_FULL; busy=1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-015 In DECODE_ADDRESS with pkt_valid=1 and data_in!=3, the FSM SHALL latch data_in into a 2-bit target register (held at its value in all other cycles).
REQ-016 From DECODE_ADDRESS, the FSM SHALL go to LOAD_FIRST_DATA if pkt_valid, data_in!=3 and fifo_empty[data_in]=1; to WAIT_TILL_EMPTY if pkt_valid, data_in!=3 and fifo_empty[data_in]=0; and otherwise stay in DECODE_ADDRESS (address 3 packets are dropped).
REQ-017 From LOAD_FIRST_DATA, the FSM SHALL go to LOAD_DATA unconditionally.
REQ-018 From LOAD_DATA, the FSM SHALL go to FIFO_FULL_STATE if fifo_full=1; else to LOAD_PARITY if pkt_valid=0; else stay in LOAD_DATA (fifo_full has priority).
REQ-019 From FIFO_FULL_STATE, the FSM SHALL stay while fifo_full=1, else go to LOAD_AFTER_FULL.
REQ-020 From LOAD_AFTER_FULL, the FSM SHALL go to DECODE_ADDRESS if parity_done=1; else to LOAD_PARITY if low_packet_valid=1; else to LOAD_DATA.
REQ-021 From LOAD_PARITY, the FSM SHALL go to CHECK_PARITY_ERROR unconditionally.
REQ-022 From CHECK_PARITY_ERROR, the FSM SHALL go to FIFO_FULL_STATE if fifo_full=1, else to DECODE_ADDRESS.
REQ-023 From WAIT_TILL_EMPTY, the FSM SHALL go to LOAD_FIRST_DATA when fifo_empty[target]=1, else stay.
REQ-024 In any state other than DECODE_ADDRESS, if soft_reset[target]=1, the next state SHALL be DECODE_ADDRESS, overriding REQ-017..REQ-023 (resetn still has higher priority).
REQ-025 Soft resets of non-target FIFOs SHALL have no effect on the FSM.

Reset
REQ-026 With resetn=0 at a clock edge, state SHALL become DECODE_ADDRESS, target SHALL become 0 and the watchdog counter SHALL become 0, from any state including mid-packet.
REQ-027 After reset, the outputs SHALL be detect_add=1 and all other outputs 0.

Configuration
REQ-028 When macro ROUTER_FSM_WDOG_EN is defined, a 5-bit counter SHALL increment each cycle the FSM remains in FIFO_FULL_STATE or WAIT_TILL_EMPTY, and SHALL clear on any other state or on a state change.
REQ-029 With ROUTER_FSM_WDOG_EN defined, when the counter reaches 31 the next state SHALL be DECODE_ADDRESS, wdog_timeout SHALL be 1 for exactly that cycle, and the counter SHALL clear.
REQ-030 Without ROUTER_FSM_WDOG_EN, the counter SHALL be absent, wdog_timeout SHALL be tied to 0, and the port list SHALL be unchanged.

Verification
REQ-031 Scenario: reset, then pkt_valid=1 with data_in=1 and fifo_empty_1=1 -> the states SHALL be DA, LFD, then LD; write_enb_reg=1 from LD onward.
REQ-032 Scenario: in LD, pkt_valid drops with fifo_full=0 -> the states SHALL be LP then CPE (rst_int_reg=1 for one cycle), then DA.
REQ-033 Scenario: in LD, fifo_full=1 for 3 cycles -> FFS SHALL hold for 3 cycles with full_state=1 and busy=1, then LAF with parity_done=0 and low_packet_valid=0 -> LD.
REQ-034 Scenario: header data_in=2 with fifo_empty_2=0 -> WTE; then soft_reset_0 pulses -> the FSM SHALL stay in WTE; then soft_reset_2 pulses -> the FSM SHALL go to DA.
REQ-035 Scenario: header data_in=3 -> the FSM SHALL stay in DA and the target SHALL be unchanged.
REQ-036 Scenario: with ROUTER_FSM_WDOG_EN defined, fifo_full held at 1 in FFS -> after 31 cycles in FFS the FSM SHALL go to DA with wdog_timeout=1 for one cycle; without the macro, FFS SHALL persist and wdog_timeout SHALL stay 0.
